l2_req_arbiter: RTL and testbench
=================================

Name: l2_req_arbiter

Overview:
- Upstream front-end of the shared L2 cache. Accepts miss/writeback requests from NUM_CORES private L1 controllers and issues them one at a time to the L2 request channel.
- Arbitration is round-robin. The output stage is registered.
- Routes each L2 response back to the originating core by ID.
- Enforces at most one outstanding request per core.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 32, request address width.
- DATA_W, 64, write/read data width.
- ID_W, $clog2(NUM_CORES), core ID width. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
- core_req_valid  in  NUM_CORES  per-core request valid
- core_req_ready  out  NUM_CORES  per-core grant/accept
- core_req_addr  in  NUM_CORES*ADDR_W  per-core address; core i at [i*ADDR_W +: ADDR_W]
- core_req_we  in  NUM_CORES  per-core write enable
- core_req_wdata  in  NUM_CORES*DATA_W  per-core write data
- l2_req_valid  out  1  request to L2 valid
- l2_req_ready  in  1  L2 accepts request
- l2_req_addr  out  ADDR_W  request address
- l2_req_we  out  1  write enable
- l2_req_wdata  out  DATA_W  write data
- l2_req_id  out  ID_W  originating core
- l2_resp_valid  in  1  L2 response valid (always accepted)
- l2_resp_id  in  ID_W  response destination core
- l2_resp_rdata  in  DATA_W  read data (don't-care for writes)
- core_resp_valid  out  NUM_CORES  one-hot response strobe
- core_resp_rdata  out  DATA_W  response data, shared by all cores
- err_spurious_resp  out  1  sticky; response arrived for a core with no outstanding request

Behaviour:
- Reset values:
  - All outputs 0.
  - busy[] cleared.
  - Output slot empty.
  - RR pointer set so core 0 has top priority on the first arbitration.
  - A reset mid-transfer drops any pending l2_req. The L2 must be reset in the same cycle.
- Eligibility: core i is eligible when core_req_valid[i] && !busy[i].
- Slot free: the slot is free when !l2_req_valid || l2_req_ready.
- Grant:
  - When the slot is free and any core is eligible, pick the first eligible core starting from last_grant+1, wrapping modulo NUM_CORES.
  - core_req_ready is combinational, one-hot or zero, and is asserted only for the granted core.
  - A handshake occurs when core_req_valid[i] && core_req_ready[i].
- On a grant at edge T:
  - Load addr/we/wdata/id into the output register.
  - l2_req_valid=1 from T+1 (1-cycle latency).
  - Set busy[i]; last_grant<=i.
- Back-to-back grants: an accept and a new grant may occur in the same cycle, giving one request per cycle at full throughput.
- Stall: while l2_req_valid && !l2_req_ready, all l2_req_* hold stable and core_req_ready=0.
- If the slot frees and no core is eligible, l2_req_valid drops to 0 next cycle.
- Response at edge T:
  - core_resp_valid[l2_resp_id]=1 for exactly cycle T+1.
  - core_resp_rdata=l2_resp_rdata registered.
  - busy[id] clears at T.
  - The core becomes eligible in the cycle after the response.
- Response and new request from the same core in the same cycle: the core is not eligible that cycle and is granted no earlier than the next cycle.
- Spurious response (busy[id]==0): no core_resp_valid, and err_spurious_resp sets and stays set until reset.
- Response IDs >= NUM_CORES are treated as spurious.
- Every request, read or write, receives exactly one response.

Test Plan:
- Reset, then core 2 requests addr 0x1000 rd:
  - core_req_ready[2]=1 same cycle.
  - l2_req_valid=1, addr=0x1000, id=2 next cycle.
  - l2_resp_valid id=2 rdata=0xDEAD → core_resp_valid=4'b0100, rdata=0xDEAD one cycle later.
- All 4 cores valid, l2_req_ready=1, responses returned immediately → grant order 0,1,2,3,0, one per cycle after the first; no starvation over 40 cycles.
- l2_req_ready=0 for 5 cycles with 3 cores pending → l2_req_* stable and core_req_ready=0 throughout; grants resume in RR order after ready rises.
- Core 1 busy, and l2_resp id=1 coincides with a new core 1 request → no grant that cycle; grant the next cycle; core 3 request in the same window is granted first.
- l2_resp_valid id=0 with no outstanding request → no core_resp_valid and err_spurious_resp=1; stays 1 until rst=0.
- rst=0 asserted while l2_req_valid && !l2_req_ready → next cycle all outputs 0 and busy cleared; after release core 0 wins a simultaneous 0/3 request.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// ---------------------------------------------------------------------------
// l2_req_arbiter
//
// Front-end of the shared L2 cache. Collects miss/writeback requests from
// NUM_CORES private L1 controllers, picks one per cycle round-robin, and
// presents it on a registered L2 request channel. L2 responses are steered
// back to the originating core by ID. Each core may have at most one request
// outstanding; a core stays ineligible from grant until its response.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   core_req_valid/ready     per-core request handshake (ready is one-hot/zero)
//   core_req_addr/we/wdata   per-core request payload, core i at slice i
//   l2_req_valid/ready       registered request channel to L2
//   l2_req_addr/we/wdata/id  request payload and originating core
//   l2_resp_valid/id/rdata   L2 response (always accepted)
//   core_resp_valid          one-hot, one-cycle response strobe
//   core_resp_rdata          registered response data shared by all cores
//   err_spurious_resp        sticky: response for a core with nothing pending
// ---------------------------------------------------------------------------
module l2_req_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = $clog2(NUM_CORES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  output logic [NUM_CORES-1:0]          core_req_ready,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_req_addr,
  input  logic [NUM_CORES-1:0]          core_req_we,
  input  logic [NUM_CORES*DATA_W-1:0]   core_req_wdata,
  output logic                          l2_req_valid,
  input  logic                          l2_req_ready,
  output logic [ADDR_W-1:0]             l2_req_addr,
  output logic                          l2_req_we,
  output logic [DATA_W-1:0]             l2_req_wdata,
  output logic [ID_W-1:0]               l2_req_id,
  input  logic                          l2_resp_valid,
  input  logic [ID_W-1:0]               l2_resp_id,
  input  logic [DATA_W-1:0]             l2_resp_rdata,
  output logic [NUM_CORES-1:0]          core_resp_valid,
  output logic [DATA_W-1:0]             core_resp_rdata,
  output logic                          err_spurious_resp
);

  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] grant_oh;
  logic [NUM_CORES-1:0] resp_hit;
  logic [ID_W-1:0]      last_grant;
  logic [ID_W-1:0]      grant_id;
  logic [ID_W-1:0]      scan_id;
  logic                 found;
  logic                 slot_free;
  logic                 do_grant;
  logic                 spurious;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 sel_we;
  logic [DATA_W-1:0]    sel_wdata;

  // busy is the registered value, so a core whose response lands this cycle
  // is still ineligible until the following cycle.
  assign eligible  = core_req_valid & ~busy;
  assign slot_free = !l2_req_valid || l2_req_ready;

  // Round-robin scan: start one past last_grant and wrap at NUM_CORES-1,
  // which also covers core counts that are not powers of two.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip the assignment would infer a latch.
    found    = 1'b0;
    grant_id = '0;
    scan_id  = last_grant;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_id = (scan_id == ID_W'(NUM_CORES - 1)) ? '0 : scan_id + 1'b1;
      if (!found && eligible[scan_id]) begin
        found    = 1'b1;
        grant_id = scan_id;
      end
    end
  end

  // Grants are suppressed while reset is held so core_req_ready reads 0.
  assign do_grant = rst && slot_free && found;

  always_comb begin
    grant_oh  = '0;
    resp_hit  = '0;
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      grant_oh[i] = do_grant && (grant_id == ID_W'(i));
      // A response only counts if the addressed core really has one pending;
      // IDs beyond NUM_CORES-1 match no core and fall out as spurious.
      resp_hit[i] = l2_resp_valid && (l2_resp_id == ID_W'(i)) && busy[i];
      if (grant_id == ID_W'(i)) begin
        sel_addr  = core_req_addr[i*ADDR_W +: ADDR_W];
        sel_we    = core_req_we[i];
        sel_wdata = core_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign spurious       = l2_resp_valid && !(|resp_hit);
  assign core_req_ready = grant_oh;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the payload registers are reset too, not only the valid bits,
      // because all outputs must read zero during and right after reset.
      busy              <= '0;
      last_grant        <= ID_W'(NUM_CORES - 1);
      l2_req_valid      <= 1'b0;
      l2_req_addr       <= '0;
      l2_req_we         <= 1'b0;
      l2_req_wdata      <= '0;
      l2_req_id         <= '0;
      core_resp_valid   <= '0;
      core_resp_rdata   <= '0;
      err_spurious_resp <= 1'b0;
    end else begin
      if (do_grant) begin
        l2_req_valid <= 1'b1;
        l2_req_addr  <= sel_addr;
        l2_req_we    <= sel_we;
        l2_req_wdata <= sel_wdata;
        l2_req_id    <= grant_id;
        last_grant   <= grant_id;
      end else if (slot_free) begin
        l2_req_valid <= 1'b0;
      end

      // A core cannot be both granted (needs !busy) and legitimately
      // answered (needs busy) in one cycle, so clear and set never collide.
      busy            <= (busy & ~resp_hit) | grant_oh;
      core_resp_valid <= resp_hit;
      if (|resp_hit) begin
        core_resp_rdata <= l2_resp_rdata;
      end
      if (spurious) begin
        err_spurious_resp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_l2_req_arbiter
//
// Directed bench for l2_req_arbiter (4 cores, 32-bit address, 64-bit data).
// Inputs change 1 ns after the rising edge; outputs are compared a further
// 1 ns later, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_l2_req_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NC-1:0]      core_req_valid;
  logic [NC-1:0]      core_req_ready;
  logic [NC*AW-1:0]   core_req_addr;
  logic [NC-1:0]      core_req_we;
  logic [NC*DW-1:0]   core_req_wdata;
  logic               l2_req_valid;
  logic               l2_req_ready;
  logic [AW-1:0]      l2_req_addr;
  logic               l2_req_we;
  logic [DW-1:0]      l2_req_wdata;
  logic [IW-1:0]      l2_req_id;
  logic               l2_resp_valid;
  logic [IW-1:0]      l2_resp_id;
  logic [DW-1:0]      l2_resp_rdata;
  logic [NC-1:0]      core_resp_valid;
  logic [DW-1:0]      core_resp_rdata;
  logic               err_spurious_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_req_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .core_req_valid    (core_req_valid),
    .core_req_ready    (core_req_ready),
    .core_req_addr     (core_req_addr),
    .core_req_we       (core_req_we),
    .core_req_wdata    (core_req_wdata),
    .l2_req_valid      (l2_req_valid),
    .l2_req_ready      (l2_req_ready),
    .l2_req_addr       (l2_req_addr),
    .l2_req_we         (l2_req_we),
    .l2_req_wdata      (l2_req_wdata),
    .l2_req_id         (l2_req_id),
    .l2_resp_valid     (l2_resp_valid),
    .l2_resp_id        (l2_resp_id),
    .l2_resp_rdata     (l2_resp_rdata),
    .core_resp_valid   (core_resp_valid),
    .core_resp_rdata   (core_resp_rdata),
    .err_spurious_resp (err_spurious_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_valid = '0;
    core_req_we    = '0;
    l2_req_ready   = 1'b1;
    l2_resp_valid  = 1'b0;
    l2_resp_id     = '0;
    l2_resp_rdata  = '0;
  endtask

  task automatic set_core(input int i, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] d);
    core_req_addr[i*AW +: AW]  = a;
    core_req_we[i]             = we;
    core_req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    core_req_addr  = '0;
    core_req_wdata = '0;
    rst = 1'b0;
    core_req_valid = '1;
    tick();
    tick();
    checks++;
    if (core_req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", core_req_ready);
    end
    checks++;
    if ({l2_req_valid, l2_req_we, l2_req_id, l2_req_addr, l2_req_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_l2_req: valid=%b we=%b id=%0d addr=%h wdata=%h expected all 0",
               l2_req_valid, l2_req_we, l2_req_id, l2_req_addr, l2_req_wdata);
    end
    checks++;
    if ({core_resp_valid, core_resp_rdata, err_spurious_resp} !== '0) begin
      errors++;
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b expected all 0",
               core_resp_valid, core_resp_rdata, err_spurious_resp);
    end
    core_req_valid = '0;
  endtask

  task automatic test_basic_read();
    do_reset();
    set_core(2, 32'h1000, 1'b0, '0);
    core_req_valid = 4'b0100;
    #1;
    checks++;
    if (core_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL read_ready: got %b expected 0100", core_req_ready);
    end
    tick();
    core_req_valid = '0;
    checks++;
    if ({l2_req_valid, l2_req_addr, l2_req_id, l2_req_we} !== {1'b1, 32'h1000, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL read_l2_req: valid=%b addr=%h id=%0d we=%b expected 1 00001000 2 0",
               l2_req_valid, l2_req_addr, l2_req_id, l2_req_we);
    end
    l2_resp_valid = 1'b1;
    l2_resp_id    = 2'd2;
    l2_resp_rdata = 64'hDEAD;
    tick();
    l2_resp_valid = 1'b0;
    checks++;
    if (l2_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_l2_drop: got %b expected 0", l2_req_valid);
    end
    checks++;
    if (core_resp_valid !== 4'b0100 || core_resp_rdata !== 64'hDEAD) begin
      errors++;
      $display("FAIL read_resp: valid=%b rdata=%h expected 0100 dead",
               core_resp_valid, core_resp_rdata);
    end
    tick();
    checks++;
    if (core_resp_valid !== 4'b0000 || err_spurious_resp !== 1'b0) begin
      errors++;
      $display("FAIL read_resp_pulse: valid=%b err=%b expected 0000 0",
               core_resp_valid, err_spurious_resp);
    end
  endtask

  task automatic test_write();
    do_reset();
    set_core(1, 32'h0ABC, 1'b1, 64'h1122_3344_5566_7788);
    core_req_valid = 4'b0010;
    tick();
    core_req_valid = '0;
    checks++;
    if ({l2_req_valid, l2_req_we, l2_req_id, l2_req_addr, l2_req_wdata} !==
        {1'b1, 1'b1, 2'd1, 32'h0ABC, 64'h1122_3344_5566_7788}) begin
      errors++;
      $display("FAIL write_l2_req: valid=%b we=%b id=%0d addr=%h wdata=%h expected 1 1 1 00000abc 1122334455667788",
               l2_req_valid, l2_req_we, l2_req_id, l2_req_addr, l2_req_wdata);
    end
    l2_resp_valid = 1'b1;
    l2_resp_id    = 2'd1;
    tick();
    l2_resp_valid = 1'b0;
    checks++;
    if (core_resp_valid !== 4'b0010) begin
      errors++;
      $display("FAIL write_resp: got %b expected 0010", core_resp_valid);
    end
  endtask

  // All cores request continuously, L2 accepts at once and answers in the
  // accept cycle: cycle n grants core (n-1)%4, the L2 port shows core
  // (n-2)%4 and the response strobe shows core (n-3)%4.
  task automatic test_round_robin();
    logic [NC-1:0] exp_ready;
    logic [NC-1:0] exp_resp;
    logic [IW-1:0] exp_id;
    logic [AW-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < NC; i++) set_core(i, AW'(32'h100 * (i + 1)), 1'b0, '0);
    core_req_valid = '1;
    for (int n = 1; n <= 40; n++) begin
      exp_ready = NC'(1) << ((n - 1) % NC);
      exp_id    = IW'((n - 2 + NC) % NC);
      exp_addr  = AW'(32'h100 * (((n - 2 + NC) % NC) + 1));
      exp_resp  = NC'(1) << ((n - 3 + NC) % NC);
      l2_resp_valid = (n >= 2);
      l2_resp_id    = exp_id;
      #1;
      checks++;
      if (core_req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: got %b expected %b", n, core_req_ready, exp_ready);
      end
      if (n >= 2) begin
        checks++;
        if ({l2_req_valid, l2_req_id, l2_req_addr} !== {1'b1, exp_id, exp_addr}) begin
          errors++;
          $display("FAIL rr_l2_req cycle %0d: valid=%b id=%0d addr=%h expected 1 %0d %h",
                   n, l2_req_valid, l2_req_id, l2_req_addr, exp_id, exp_addr);
        end
      end
      if (n >= 3) begin
        checks++;
        if (core_resp_valid !== exp_resp) begin
          errors++;
          $display("FAIL rr_resp cycle %0d: got %b expected %b", n, core_resp_valid, exp_resp);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    l2_req_ready = 1'b0;
    set_core(0, 32'h00A0, 1'b1, 64'h55);
    set_core(1, 32'h00B0, 1'b0, '0);
    set_core(2, 32'h00C0, 1'b0, '0);
    core_req_valid = 4'b0111;
    #1;
    checks++;
    if (core_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL stall_first_grant: got %b expected 0001", core_req_ready);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({l2_req_valid, l2_req_id, l2_req_addr, l2_req_we, l2_req_wdata} !==
          {1'b1, 2'd0, 32'h00A0, 1'b1, 64'h55}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: valid=%b id=%0d addr=%h we=%b wdata=%h expected 1 0 000000a0 1 55",
                 k, l2_req_valid, l2_req_id, l2_req_addr, l2_req_we, l2_req_wdata);
      end
      checks++;
      if (core_req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_ready cycle %0d: got %b expected 0000", k, core_req_ready);
      end
      tick();
    end
    l2_req_ready = 1'b1;
    #1;
    checks++;
    if (core_req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stall_resume_grant1: got %b expected 0010", core_req_ready);
    end
    tick();
    checks++;
    if (l2_req_id !== 2'd1 || l2_req_addr !== 32'h00B0 || core_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stall_resume_grant2: id=%0d addr=%h ready=%b expected 1 000000b0 0100",
               l2_req_id, l2_req_addr, core_req_ready);
    end
    tick();
    checks++;
    if (l2_req_id !== 2'd2 || core_req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL stall_all_busy: id=%0d ready=%b expected 2 0000", l2_req_id, core_req_ready);
    end
    tick();
    checks++;
    if (l2_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got %b expected 0", l2_req_valid);
    end
    idle_inputs();
  endtask

  task automatic test_resp_same_cycle();
    do_reset();
    set_core(1, 32'h0111, 1'b0, '0);
    set_core(3, 32'h0333, 1'b0, '0);
    core_req_valid = 4'b0010;
    tick();
    core_req_valid = '0;
    tick();
    core_req_valid = 4'b1010;
    l2_resp_valid  = 1'b1;
    l2_resp_id     = 2'd1;
    l2_resp_rdata  = 64'h77;
    #1;
    checks++;
    if (core_req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL same_cycle_grant: got %b expected 1000", core_req_ready);
    end
    tick();
    l2_resp_valid  = 1'b0;
    core_req_valid = 4'b0010;
    #1;
    checks++;
    if (core_resp_valid !== 4'b0010 || core_resp_rdata !== 64'h77) begin
      errors++;
      $display("FAIL same_cycle_resp: valid=%b rdata=%h expected 0010 77",
               core_resp_valid, core_resp_rdata);
    end
    checks++;
    if (l2_req_id !== 2'd3 || l2_req_addr !== 32'h0333 || core_req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL same_cycle_next: id=%0d addr=%h ready=%b expected 3 00000333 0010",
               l2_req_id, l2_req_addr, core_req_ready);
    end
    tick();
    core_req_valid = '0;
    checks++;
    if (l2_req_id !== 2'd1 || l2_req_addr !== 32'h0111 || core_resp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL same_cycle_regrant: id=%0d addr=%h resp=%b expected 1 00000111 0000",
               l2_req_id, l2_req_addr, core_resp_valid);
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    l2_resp_valid = 1'b1;
    l2_resp_id    = 2'd0;
    l2_resp_rdata = 64'hBAD;
    tick();
    l2_resp_valid = 1'b0;
    checks++;
    if (core_resp_valid !== 4'b0000 || err_spurious_resp !== 1'b1) begin
      errors++;
      $display("FAIL spurious_flag: resp=%b err=%b expected 0000 1",
               core_resp_valid, err_spurious_resp);
    end
    set_core(0, 32'h0040, 1'b0, '0);
    core_req_valid = 4'b0001;
    tick();
    core_req_valid = '0;
    l2_resp_valid  = 1'b1;
    l2_resp_id     = 2'd0;
    tick();
    l2_resp_valid  = 1'b0;
    checks++;
    if (core_resp_valid !== 4'b0001 || err_spurious_resp !== 1'b1) begin
      errors++;
      $display("FAIL spurious_sticky: resp=%b err=%b expected 0001 1",
               core_resp_valid, err_spurious_resp);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (err_spurious_resp !== 1'b0) begin
      errors++;
      $display("FAIL spurious_clear: got %b expected 0", err_spurious_resp);
    end
  endtask

  task automatic test_reset_mid_transfer();
    do_reset();
    l2_req_ready = 1'b0;
    set_core(2, 32'h2222, 1'b1, 64'hCAFE);
    core_req_valid = 4'b0100;
    tick();
    core_req_valid = '0;
    tick();
    checks++;
    if (l2_req_valid !== 1'b1 || l2_req_id !== 2'd2) begin
      errors++;
      $display("FAIL midrst_pending: valid=%b id=%0d expected 1 2", l2_req_valid, l2_req_id);
    end
    rst = 1'b0;
    set_core(0, 32'h0010, 1'b0, '0);
    set_core(3, 32'h0030, 1'b0, '0);
    core_req_valid = 4'b1001;
    tick();
    checks++;
    if ({l2_req_valid, l2_req_we, l2_req_id, l2_req_addr, l2_req_wdata,
         core_resp_valid, core_req_ready} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b we=%b id=%0d addr=%h wdata=%h resp=%b ready=%b expected all 0",
               l2_req_valid, l2_req_we, l2_req_id, l2_req_addr, l2_req_wdata,
               core_resp_valid, core_req_ready);
    end
    rst = 1'b1;
    l2_req_ready = 1'b1;
    #1;
    checks++;
    if (core_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_priority: got %b expected 0001", core_req_ready);
    end
    tick();
    core_req_valid = 4'b1101;
    #1;
    checks++;
    if (core_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_busy_cleared: got %b expected 0100", core_req_ready);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write();
    test_round_robin();
    test_stall();
    test_resp_same_cycle();
    test_spurious();
    test_reset_mid_transfer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
